sha256_msg_sched: RTL and testbench

Parametrised SHA-256 message scheduler that accepts a padded message of `NBLOCKS` 512-bit blocks and streams the full expanded schedule W[0..ROUNDS-1] for each block, one 32-bit word per cycle. It extends the existing block splitter, which only separates a fixed two-block message into 16 words per block, by adding:

- a configurable block count,
- the σ0/σ1 expansion to 64 words,
- valid/ready handshakes on both sides.

It sits between message padding and the compression rounds.

---
 rtl/sha256_msg_sched.sv | 212 +++++++++++++++++++++
 tb/tb_sha256_msg_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched
//
// Purpose: takes a padded message of NBLOCKS 512-bit blocks and streams the
// expanded SHA-256 message schedule W[0..ROUNDS-1] of each block, one 32-bit
// word per cycle, with valid/ready handshakes on both sides. Blocks are
// expanded independently; no hash-state chaining happens here.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   in_valid      message present on `message`
//   in_ready      idle and able to accept a message (registered)
//   message       NBLOCKS*512-bit padded message, block 0 / word 0 in the MSBs
//   w_valid       w_data holds a schedule word
//   w_ready       downstream accepts the current word
//   w_data        schedule word W[t]
//   w_round       t of the current word
//   w_block       block index of the current word
//   w_last        high when t == ROUNDS-1
//   w_last_block  high while w_block == NBLOCKS-1
//   done          one-cycle pulse after the final word of the final block
module sha256_msg_sched #(
  parameter int NBLOCKS = 2,
  parameter int ROUNDS  = 64,
  parameter int BW      = (NBLOCKS > 1) ? $clog2(NBLOCKS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NBLOCKS*512-1:0] message,
  output logic                   w_valid,
  input  logic                   w_ready,
  output logic [31:0]            w_data,
  output logic [5:0]             w_round,
  output logic [BW-1:0]          w_block,
  output logic                   w_last,
  output logic                   w_last_block,
  output logic                   done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int NWORDS = NBLOCKS * 16;
  // Word index is {block, word-in-block}; the lookup table is padded to a
  // power of two so that concatenated index never runs past the array.
  localparam int IW     = BW + 4;
  localparam int NSLOTS = 1 << IW;

  localparam logic [5:0]    T_LAST = 6'(ROUNDS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NBLOCKS - 1);

  logic [1:0]             state_q, state_d;
  logic [NBLOCKS*512-1:0] msg_q, msg_d;
  logic [BW-1:0]          block_q, block_d;
  logic [5:0]             t_q, t_d;
  logic [31:0]            win_q [16];
  logic [31:0]            win_d [16];
  logic                   in_ready_q, in_ready_d;
  logic                   w_valid_q, w_valid_d;
  logic                   w_last_q, w_last_d;
  logic                   w_last_block_q, w_last_block_d;
  logic                   done_q, done_d;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Flat view of the captured message as 32-bit words, word 0 of block 0 first.
  logic [31:0] msg_words [NSLOTS];

  generate
    for (genvar gi = 0; gi < NSLOTS; gi++) begin : g_words
      if (gi < NWORDS) begin : g_real
        assign msg_words[gi] = msg_q[(NWORDS-1-gi)*32 +: 32];
      end else begin : g_pad
        assign msg_words[gi] = 32'h0;
      end
    end
  endgenerate

  // Next word, computed one transfer ahead. win_q[15] is the word on w_data
  // (W[t]) and win_q[i] holds W[t-15+i], so W[t+1] draws on
  // W[t-1]=win[14], W[t-6]=win[9], W[t-14]=win[1] and W[t-15]=win[0].
  // At a block boundary the window needs no flush: the first 16 words of the
  // new block come straight from the message and overwrite every slot before
  // the expansion reads any of them.
  logic          last_t;
  logic          last_blk;
  logic [BW-1:0] nxt_block;
  logic [5:0]    nxt_t;
  logic [IW-1:0] nxt_idx;
  logic [31:0]   nxt_word;

  always_comb begin
    last_t    = (t_q == T_LAST);
    last_blk  = (block_q == B_LAST);
    nxt_block = last_t ? block_q + BW'(1) : block_q;
    nxt_t     = last_t ? 6'd0 : t_q + 6'd1;
    nxt_idx   = {nxt_block, nxt_t[3:0]};
    if (nxt_t < 6'd16) begin
      nxt_word = msg_words[nxt_idx];
    end else begin
      nxt_word = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
    end
  end

  always_comb begin
    state_d        = state_q;
    msg_d          = msg_q;
    block_d        = block_q;
    t_d            = t_q;
    win_d          = win_q;
    in_ready_d     = in_ready_q;
    w_valid_d      = w_valid_q;
    w_last_d       = w_last_q;
    w_last_block_d = w_last_block_q;
    done_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        // in_ready rises on the first clock after reset and after DONE.
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          msg_d          = message;
          block_d        = '0;
          t_d            = '0;
          // W[0] is taken from the input directly so it is valid right
          // after the accepting edge.
          win_d[15]      = message[NBLOCKS*512-1 -: 32];
          w_valid_d      = 1'b1;
          in_ready_d     = 1'b0;
          w_last_d       = (T_LAST == 6'd0);
          w_last_block_d = (B_LAST == '0);
          state_d        = S_EMIT;
        end
      end

      S_EMIT: begin
        if (w_ready) begin
          if (last_t && last_blk) begin
            w_valid_d = 1'b0;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end else begin
            block_d = nxt_block;
            t_d     = nxt_t;
            for (int i = 0; i < 15; i++) begin
              win_d[i] = win_q[i+1];
            end
            win_d[15]      = nxt_word;
            w_last_d       = (nxt_t == T_LAST);
            w_last_block_d = (nxt_block == B_LAST);
          end
        end
      end

      S_DONE: begin
        in_ready_d = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      msg_q          <= '0;
      block_q        <= '0;
      t_q            <= '0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
      in_ready_q     <= 1'b0;
      w_valid_q      <= 1'b0;
      w_last_q       <= 1'b0;
      w_last_block_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      msg_q          <= msg_d;
      block_q        <= block_d;
      t_q            <= t_d;
      win_q          <= win_d;
      in_ready_q     <= in_ready_d;
      w_valid_q      <= w_valid_d;
      w_last_q       <= w_last_d;
      w_last_block_q <= w_last_block_d;
      done_q         <= done_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign w_valid      = w_valid_q;
  assign w_data       = win_q[15];
  assign w_round      = t_q;
  assign w_block      = block_q;
  assign w_last       = w_last_q;
  assign w_last_block = w_last_block_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched
//
// Directed bench for sha256_msg_sched. Two instances: the default build
// (NBLOCKS=2, ROUNDS=64) and a NBLOCKS=3, ROUNDS=16 build. Outputs of the
// instance under test are muxed onto m_* so the helper tasks serve both.
module tb_sha256_msg_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic          in_valid = 1'b0;
  logic [1023:0] message  = '0;
  logic          in_ready, w_valid, w_last, w_last_block, done;
  logic [31:0]   w_data;
  logic [5:0]    w_round;
  logic [0:0]    w_block;

  // NBLOCKS=3, ROUNDS=16 instance
  logic          in_valid3 = 1'b0;
  logic [1535:0] message3  = '0;
  logic          in_ready3, w_valid3, w_last3, w_last_block3, done3;
  logic [31:0]   w_data3;
  logic [5:0]    w_round3;
  logic [1:0]    w_block3;

  logic w_ready_tb = 1'b1;
  bit   sel = 1'b0;

  sha256_msg_sched dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .message(message), .w_valid(w_valid), .w_ready(w_ready_tb),
    .w_data(w_data), .w_round(w_round), .w_block(w_block),
    .w_last(w_last), .w_last_block(w_last_block), .done(done)
  );

  sha256_msg_sched #(.NBLOCKS(3), .ROUNDS(16)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .message(message3), .w_valid(w_valid3), .w_ready(w_ready_tb),
    .w_data(w_data3), .w_round(w_round3), .w_block(w_block3),
    .w_last(w_last3), .w_last_block(w_last_block3), .done(done3)
  );

  logic        m_valid, m_in_ready, m_last, m_lb, m_done;
  logic [31:0] m_data;
  logic [5:0]  m_round;
  logic [1:0]  m_block;
  logic [9:0]  m_meta;

  assign m_valid    = sel ? w_valid3 : w_valid;
  assign m_in_ready = sel ? in_ready3 : in_ready;
  assign m_last     = sel ? w_last3 : w_last;
  assign m_lb       = sel ? w_last_block3 : w_last_block;
  assign m_done     = sel ? done3 : done;
  assign m_data     = sel ? w_data3 : w_data;
  assign m_round    = sel ? w_round3 : w_round;
  assign m_block    = sel ? w_block3 : {1'b0, w_block};
  assign m_meta     = {m_round, m_block, m_last, m_lb};

  int total = 0;
  int bad   = 0;
  int cyc_used = 0;
  int done_cnt = 0;

  always @(posedge clk) begin
    if (done || done3) done_cnt <= done_cnt + 1;
  end

  logic [31:0] exp_data [192];
  logic [9:0]  exp_meta [192];
  logic [31:0] got_data [192];
  logic [9:0]  got_meta [192];

  localparam logic [511:0] ABC  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [1023:0] MSG_A = {ABC, 512'h0};
  localparam logic [1023:0] MSG_D = {512'h0, ABC};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ms0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ms1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Reference: textbook 64-entry schedule for one block.
  task automatic fill_block(input logic [511:0] blk, input int base, input int rounds,
                            input int b, input int nblk);
    logic [31:0] w [64];
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w[i] = blk[511 - 32*i -: 32];
      else        w[i] = ms1(w[i-2]) + w[i-7] + ms0(w[i-15]) + w[i-16];
    end
    for (int i = 0; i < rounds; i++) begin
      exp_data[base + i] = w[i];
      exp_meta[base + i] = {6'(i), 2'(b), (i == rounds - 1), (b == nblk - 1)};
    end
  endtask

  // Called at a negedge with the DUT idle; leaves us at the negedge where
  // W[0] is presented.
  task automatic accept(input logic [1535:0] m, input bit keep);
    int waited = 0;
    while (!m_in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_ready", m_in_ready, 1);
    if (sel) begin in_valid3 = 1'b1; message3 = m; end
    else     begin in_valid  = 1'b1; message  = m[1023:0]; end
    @(negedge clk);
    if (!keep) begin in_valid = 1'b0; in_valid3 = 1'b0; end
    chk("accept_in_ready_low", m_in_ready, 0);
    chk("accept_first_valid", m_valid, 1);
  endtask

  // Collect n transfers starting at the current negedge; stall = percent of
  // cycles with w_ready low. Every stalled cycle is checked for held outputs.
  task automatic collect(input int n, input int stall, input int budget);
    int got = 0;
    int cyc = 0;
    int leak = 0;
    bit held = 1'b0;
    logic [41:0] snap = '0;
    while (got < n && cyc < budget) begin
      if (held) chk($sformatf("hold_stable_c%0d", cyc), {m_data, m_meta}, snap);
      if (m_in_ready) leak++;
      w_ready_tb = (stall == 0) ? 1'b1 : ($urandom_range(99, 0) >= 32'(stall));
      if (m_valid && w_ready_tb) begin
        got_data[got] = m_data;
        got_meta[got] = m_meta;
        got++;
      end
      held = m_valid && !w_ready_tb;
      snap = {m_data, m_meta};
      cyc++;
      @(negedge clk);
    end
    w_ready_tb = 1'b1;
    chk("stream_complete", got, n);
    chk("in_ready_low_during_emit", leak, 0);
    cyc_used = cyc;
  endtask

  task automatic compare_stream(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data_%0d", tag, i), got_data[i], exp_data[i]);
      chk($sformatf("%s_meta_%0d", tag, i), got_meta[i], exp_meta[i]);
    end
  endtask

  // At the negedge right after the final transfer.
  task automatic finish_check(input string tag);
    chk({tag, "_done_pulse"}, m_done, 1);
    chk({tag, "_valid_low_in_done"}, m_valid, 0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, m_done, 0);
    chk({tag, "_in_ready_back"}, m_in_ready, 1);
  endtask

  initial begin
    #500000;
    $error("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dc;
    logic [1535:0] m3;

    // ---- reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_w_data", w_data, 0);
    chk("rst_w_round", w_round, 0);
    chk("rst_w_block", w_block, 0);
    chk("rst_w_last", w_last, 0);
    chk("rst_w_last_block", w_last_block, 0);
    chk("rst_in_ready3", in_ready3, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    chk("release_w_valid", w_valid, 0);

    // ---- A: two blocks, abc + zeros, no stalls, message scrambled mid-run
    sel = 1'b0;
    fill_block(ABC, 0, 64, 0, 2);
    fill_block(512'h0, 64, 64, 1, 2);
    accept({512'h0, MSG_A}, 1'b0);
    for (int i = 0; i < 32; i++) message[32*i +: 32] = $urandom();
    collect(128, 0, 400);
    chk("A_zero_bubbles", cyc_used, 128);
    compare_stream("A", 128);
    chk("A_W0",  got_data[0],  32'h61626380);
    chk("A_W15", got_data[15], 32'h00000018);
    chk("A_W16", got_data[16], 32'h61626380);
    chk("A_W17", got_data[17], 32'h000F0000);
    chk("A_W18", got_data[18], 32'h7DA86405);
    chk("A_blk1_t0", got_data[64], 32'h0);
    chk("A_blk1_t0_meta", got_meta[64], {6'd0, 2'd1, 1'b0, 1'b1});
    chk("A_last_t63", got_meta[63], {6'd63, 2'd0, 1'b1, 1'b0});
    finish_check("A");

    // ---- B: same message with ~50% backpressure
    accept({512'h0, MSG_A}, 1'b0);
    collect(128, 50, 2000);
    compare_stream("B", 128);
    finish_check("B");

    // ---- C: reset at t=30 of block 0, then a fresh run
    dc = done_cnt;
    accept({512'h0, MSG_A}, 1'b0);
    collect(30, 0, 100);
    chk("C_round_at_abort", m_round, 30);
    rst = 1'b0;
    #1;
    chk("C_rst_w_valid", w_valid, 0);
    chk("C_rst_in_ready", in_ready, 0);
    chk("C_rst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("C_release_in_ready", in_ready, 1);
    chk("C_no_done_on_abort", done_cnt, dc);
    accept({512'h0, MSG_A}, 1'b0);
    chk("C_fresh_W0", m_data, 32'h61626380);
    chk("C_fresh_meta", m_meta, {6'd0, 2'd0, 1'b0, 1'b0});
    collect(128, 0, 400);
    compare_stream("C", 128);
    finish_check("C");
    chk("C_single_done", done_cnt, dc + 1);

    // ---- D: in_valid held high; second message only taken after done
    accept({512'h0, MSG_A}, 1'b1);
    message = MSG_D;
    collect(128, 0, 400);
    compare_stream("D1", 128);
    chk("D_done", m_done, 1);
    chk("D_in_ready_low_at_done", m_in_ready, 0);
    @(negedge clk);
    chk("D_in_ready_after_done", m_in_ready, 1);
    chk("D_valid_idle", m_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("D_second_accept_ready", m_in_ready, 0);
    chk("D_second_accept_valid", m_valid, 1);
    fill_block(512'h0, 0, 64, 0, 2);
    fill_block(ABC, 64, 64, 1, 2);
    collect(128, 0, 400);
    compare_stream("D2", 128);
    chk("D2_blk1_W16", got_data[80], 32'h61626380);
    finish_check("D2");

    // ---- E: NBLOCKS=3, ROUNDS=16 passes raw words straight through
    sel = 1'b1;
    m3 = '0;
    for (int i = 0; i < 48; i++) begin
      m3[1535 - 32*i -: 32] = 32'hC0DE0000 + 32'(i);
      exp_data[i] = 32'hC0DE0000 + 32'(i);
      exp_meta[i] = {6'(i % 16), 2'(i / 16), (i % 16 == 15), (i / 16 == 2)};
    end
    accept(m3, 1'b0);
    collect(48, 0, 200);
    chk("E_zero_bubbles", cyc_used, 48);
    compare_stream("E", 48);
    finish_check("E");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
